d_sram2axi_bridge: RTL
======================

D_SRAM2AXI_BRIDGE -- requirements
Module: d_sram2axi_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd1; constant ID driven on arid/awid/wid.
REQ-002 SHALL have reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- req / wr  in  1 each  sram-like request; 1=write
- size  in  2  0=byte, 1=half, 2=word
- addr / wdata  in  32 each  byte address; write data
- rdata  out  32  read data, valid with data_ok
- addr_ok / data_ok  out  1 each  request accepted; transaction complete (1-cycle pulse)
- arid, araddr, arlen, arsize, arburst, arvalid  out  4/32/8/3/2/1  AXI read address
- arready  in  1
- rid, rdata_axi, rresp, rlast, rvalid  in  4/32/2/1/1  AXI read data
- rready  out  1
- awid, awaddr, awlen, awsize, awburst, awvalid  out  4/32/8/3/2/1  AXI write address
- awready  in  1
- wid, wdata_axi, wstrb, wlast, wvalid  out  4/32/4/1/1  AXI write data
- wready  in  1
- bid, bresp, bvalid  in  4/2/1  write response
- bready  out  1

Function
REQ-004 SHALL use FSM states IDLE, RADDR, RDATA, WREQ, WRESP, with at most one transaction outstanding.
REQ-005 IDLE: req=1 SHALL assert addr_ok combinationally in the same cycle and latch wr/size/addr/wdata; next state RADDR (wr=0) or WREQ (wr=1). addr_ok SHALL be 0 in every other state.
REQ-006 RADDR: arvalid=1 with latched addr; on arvalid&arready SHALL go to RDATA next cycle.
REQ-007 RDATA: rready=1; on rvalid&rready&rlast SHALL pulse data_ok for that cycle, drive rdata=rdata_axi, and return to IDLE.
REQ-008 WREQ: awvalid and wvalid SHALL both rise on entry and each SHALL drop independently after its own handshake; SHALL go to WRESP the cycle after both handshakes complete, including when both complete in the same cycle.
REQ-009 WRESP: bready=1; on bvalid&bready SHALL pulse data_ok for one cycle and return to IDLE.
REQ-010 Fixed fields SHALL be arlen=awlen=0, arburst=awburst=2'b01, wlast=1; arsize=awsize={1'b0,size}.
REQ-011 wstrb SHALL be generated from latched size/addr[1:0]:
- byte: 0001/0010/0100/1000 for offset 0..3
- half: 0011 (addr[1]=0) or 1100
- word, or size=3: 1111
REQ-012 wdata_axi SHALL be the latched wdata unshifted; awaddr/araddr SHALL be the latched addr unaligned.
REQ-013 rresp/bresp/rid/bid SHALL be ignored; errors are not signalled to the requester.
REQ-014 rdata SHALL be don't-care when data_ok=0; valids SHALL stay high until handshake regardless of req.
REQ-015 A back-to-back req in the data_ok cycle SHALL NOT be accepted until IDLE is reached the next cycle.

Reset
REQ-016 On rst, state SHALL be IDLE; all valid/ready/addr_ok/data_ok outputs SHALL be 0; latches SHALL clear to 0.
REQ-017 rst mid-transaction SHALL abandon the transaction and generate no data_ok; rst has priority over every handshake.

Structure
REQ-018 A shared package SHALL hold the state enum, AXI_BURST_INCR=2'b01, and size encodings.
REQ-019 A single sub-module, wstrb_gen (size, addr[1:0] -> wstrb), SHALL be used; everything else SHALL be inline.

Verification
REQ-020 Read word 0x1000_0004, arready=1 immediately, rvalid+rlast 2 cycles later with 0xDEADBEEF -> araddr=0x1000_0004, arsize=2, data_ok 1 cycle, rdata=0xDEADBEEF.
REQ-021 Write byte addr 0x...3, wdata 0xAA000000 -> wstrb=1000, awsize=0, data_ok only after bvalid.
REQ-022 Write half addr 0x...2 with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held; WRESP entered only after AW handshake.
REQ-023 req held continuously across two reads -> exactly two addr_ok pulses, the second no earlier than the cycle after the first data_ok.
REQ-024 rst asserted in RDATA, then rvalid -> no data_ok, all valids 0, next req accepted normally.

Source files
------------

// File: rtl/d_sram2axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI single-beat bridge:
// FSM state encoding, fixed AXI field values and SRAM size codes.
package d_sram2axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4
    } state_e;

    // Every transfer is a single beat of an incrementing burst.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // SRAM-side size encodings (also the low bits of AXI AxSIZE).
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/d_sram2axi_bridge_wstrb_gen.sv
// Write-strobe generator: maps the access size and the low address bits
// onto the four AXI byte lanes. Size 3 is treated like a full word.
module wstrb_gen
    import d_sram2axi_bridge_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] wstrb_o
);

    // Decode size/offset into a lane mask.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        wstrb_o = 4'b1111;
        case (size_i)
            SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
            SIZE_HALF: wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            default:   wstrb_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/d_sram2axi_bridge.sv
// SRAM-like to AXI bridge. One transaction at a time: a request is accepted
// in IDLE, issued as a single-beat AXI read or write, and completed with a
// one-cycle data_ok. Response codes and IDs from the slave are ignored.
module d_sram2axi_bridge
    import d_sram2axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    // SRAM-like side
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
    // AXI read address
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data
    input  logic [3:0]  rid,
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AXI write address
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    // AXI write data
    output logic [3:0]  wid,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // AXI write response
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    // Slave IDs and response codes carry nothing the requester can use.
    logic unused_resp;
    assign unused_resp = &{1'b0, rid, rresp, bid, bresp};

    // Handshake outputs are decoded from state and forced low while rst is
    // high, so reset wins over any handshake in progress that cycle.
    assign addr_ok = !rst && (state_q == ST_IDLE) && req;
    assign arvalid = !rst && (state_q == ST_RADDR);
    assign rready  = !rst && (state_q == ST_RDATA);
    assign awvalid = !rst && (state_q == ST_WREQ) && !aw_done_q;
    assign wvalid  = !rst && (state_q == ST_WREQ) && !w_done_q;
    assign bready  = !rst && (state_q == ST_WRESP);
    assign data_ok = wr_q ? (bvalid && bready) : (rvalid && rready && rlast);
    assign rdata   = rdata_axi;

    // Fixed and latched AXI request fields.
    assign arid      = AXI_ID;
    assign araddr    = addr_q;
    assign arlen     = AXI_LEN_SINGLE;
    assign arsize    = {1'b0, size_q};
    assign arburst   = AXI_BURST_INCR;
    assign awid      = AXI_ID;
    assign awaddr    = addr_q;
    assign awlen     = AXI_LEN_SINGLE;
    assign awsize    = {1'b0, size_q};
    assign awburst   = AXI_BURST_INCR;
    assign wid       = AXI_ID;
    assign wdata_axi = wdata_q;
    assign wlast     = 1'b1;

    wstrb_gen u_wstrb_gen (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .wstrb_o   (wstrb)
    );

    // Next-state, request latching and per-channel write handshake tracking.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d      = wr;
                    size_d    = size;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = wr ? ST_WREQ : ST_RADDR;
                end
            end
            ST_RADDR: begin
                if (arvalid && arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (rvalid && rready && rlast) state_d = ST_IDLE;
            end
            ST_WREQ: begin
                // AW and W may complete in either order or together.
                aw_done_d = aw_done_q || (awvalid && awready);
                w_done_d  = w_done_q  || (wvalid && wready);
                if (aw_done_d && w_done_d) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (bvalid && bready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the request latches are cleared too, so the AXI address/data
            // fields read back as zero after reset instead of stale values.
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its peers.
            state_q   <= state_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
